// File: rtl/m_cnt_arb.sv
// Shared counter with a four-way round-robin arbiter. Each grant adds the
// winner's step to the counter and flags a carry out of WIDTH bits.
//
// state | meaning
// IDLE  | no grant issued on the last edge (r_gnt = 0)
// GNT   | one requester granted on the last edge (r_gnt one-hot)
module m_cnt_arb #(
    parameter int WIDTH = 8
) (
    input  logic               w_clk,
    input  logic               w_rst_n,
    input  logic [3:0]         w_req,
    input  logic [4*WIDTH-1:0] w_step,
    input  logic               w_clr,
    output logic [3:0]         r_gnt,
    output logic [WIDTH-1:0]   r_cnt,
    output logic               r_wrap,
    output logic               r_busy
);

    typedef enum logic {IDLE = 1'b0, GNT = 1'b1} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [3:0]       eligible;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic [WIDTH-1:0] step_sel;
    logic [WIDTH:0]   sum;

    // A requester whose grant is currently high sits out this edge, so a
    // held request is serviced at most every other cycle.
    always_comb begin
        eligible = w_req & ~r_gnt;
        found    = 1'b0;
        win      = 2'd0;
        idx      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        step_sel = w_step[win*WIDTH +: WIDTH];
        sum      = {1'b0, r_cnt} + {1'b0, step_sel};
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd3;
            r_gnt  <= 4'b0000;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_busy <= 1'b0;
        end else if (w_clr) begin
            // Pending requests are left alone and win on the next open edge.
            state  <= IDLE;
            r_gnt  <= 4'b0000;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            case (state)
                IDLE, GNT: begin
                    if (found) begin
                        state  <= GNT;
                        ptr    <= win;
                        r_gnt  <= 4'b0001 << win;
                        r_cnt  <= sum[WIDTH-1:0];
                        r_wrap <= sum[WIDTH];
                        r_busy <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        r_gnt  <= 4'b0000;
                        r_wrap <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    r_gnt  <= 4'b0000;
                    r_wrap <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_cnt_arb.sv
// Directed bench for m_cnt_arb: reset, single grant, rotation, wrap,
// held request, clear, zero step and asynchronous reset mid-grant.
module tb_m_cnt_arb;

    localparam int WIDTH = 8;

    logic               w_clk = 1'b0;
    logic               w_rst_n = 1'b0;
    logic [3:0]         w_req = 4'b0000;
    logic [4*WIDTH-1:0] w_step = '0;
    logic               w_clr = 1'b0;
    logic [3:0]         r_gnt;
    logic [WIDTH-1:0]   r_cnt;
    logic               r_wrap;
    logic               r_busy;

    int n_cmp = 0;
    int n_err = 0;

    m_cnt_arb #(.WIDTH(WIDTH)) dut (
        .w_clk  (w_clk),
        .w_rst_n(w_rst_n),
        .w_req  (w_req),
        .w_step (w_step),
        .w_clr  (w_clr),
        .r_gnt  (r_gnt),
        .r_cnt  (r_cnt),
        .r_wrap (r_wrap),
        .r_busy (r_busy)
    );

    always #5 w_clk = ~w_clk;

    // Returns 1 ns after a rising edge; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Pulses reset between edges and checks outputs clear without a clock.
    task automatic test_reset();
        w_req   = 4'b0000;
        w_step  = '0;
        w_clr   = 1'b0;
        #2;
        w_rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({r_gnt, r_cnt, r_wrap, r_busy} !== 14'd0) begin
            n_err++;
            $display("FAIL reset: gnt=%b cnt=%0d wrap=%b busy=%b, want all 0", r_gnt, r_cnt, r_wrap, r_busy);
        end
        w_rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] eg[3] = '{4'b0001, 4'b0000, 4'b0000};
        test_reset();
        w_step = {8'd0, 8'd0, 8'd0, 8'd3};
        w_req  = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (r_gnt[0]) w_req = 4'b0000;
            n_cmp++;
            if (r_gnt !== eg[i] || r_cnt !== 8'd3 || r_busy !== (eg[i] != 0)) begin
                n_err++;
                $display("FAIL single[%0d]: gnt=%b cnt=%0d busy=%b, want gnt=%b cnt=3", i, r_gnt, r_cnt, r_busy, eg[i]);
            end
        end
    endtask

    task automatic test_rotate();
        logic [3:0] eg[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] ec[5] = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd16};
        test_reset();
        w_step = {8'd8, 8'd4, 8'd2, 8'd1};
        w_req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (r_gnt !== eg[i] || r_cnt !== ec[i] || r_busy !== 1'b1) begin
                n_err++;
                $display("FAIL rotate[%0d]: gnt=%b cnt=%0d busy=%b, want gnt=%b cnt=%0d busy=1", i, r_gnt, r_cnt, r_busy, eg[i], ec[i]);
            end
        end
        w_req = 4'b0000;
    endtask

    task automatic test_wrap();
        test_reset();
        w_step = {8'd0, 8'd0, 8'd0, 8'd250};
        w_req  = 4'b0001;
        tick();
        w_req  = 4'b0000;
        w_step = {8'd0, 8'd0, 8'd0, 8'd10};
        n_cmp++;
        if (r_cnt !== 8'd250 || r_wrap !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pre: cnt=%0d wrap=%b, want cnt=250 wrap=0", r_cnt, r_wrap);
        end
        tick();
        w_req = 4'b0001;
        tick();
        w_req = 4'b0000;
        n_cmp++;
        if (r_cnt !== 8'd4 || r_wrap !== 1'b1 || r_gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_hit: cnt=%0d wrap=%b gnt=%b, want cnt=4 wrap=1 gnt=0001", r_cnt, r_wrap, r_gnt);
        end
        tick();
        n_cmp++;
        if (r_cnt !== 8'd4 || r_wrap !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_post: cnt=%0d wrap=%b, want cnt=4 wrap=0", r_cnt, r_wrap);
        end
    endtask

    task automatic test_hold();
        logic [3:0] eg[6] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        logic [7:0] ec[6] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
        test_reset();
        w_step = {8'd0, 8'd0, 8'd0, 8'd1};
        w_req  = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (r_gnt !== eg[i] || r_cnt !== ec[i] || r_busy !== eg[i][0]) begin
                n_err++;
                $display("FAIL hold[%0d]: gnt=%b cnt=%0d busy=%b, want gnt=%b cnt=%0d", i, r_gnt, r_cnt, r_busy, eg[i], ec[i]);
            end
        end
        w_req = 4'b0000;
    endtask

    task automatic test_clr();
        test_reset();
        w_step = {8'd0, 8'd9, 8'd0, 8'd0};
        w_req  = 4'b0100;
        tick();
        w_req  = 4'b0000;
        tick();
        n_cmp++;
        if (r_cnt !== 8'd9) begin
            n_err++;
            $display("FAIL clr_setup: cnt=%0d, want 9", r_cnt);
        end
        w_req = 4'b0100;
        w_clr = 1'b1;
        tick();
        w_clr = 1'b0;
        n_cmp++;
        if (r_cnt !== 8'd0 || r_gnt !== 4'b0000 || r_busy !== 1'b0) begin
            n_err++;
            $display("FAIL clr_apply: cnt=%0d gnt=%b busy=%b, want cnt=0 gnt=0000 busy=0", r_cnt, r_gnt, r_busy);
        end
        tick();
        w_req = 4'b0000;
        n_cmp++;
        if (r_gnt !== 4'b0100 || r_cnt !== 8'd9) begin
            n_err++;
            $display("FAIL clr_resume: gnt=%b cnt=%0d, want gnt=0100 cnt=9", r_gnt, r_cnt);
        end
    endtask

    task automatic test_step0();
        test_reset();
        w_step = {8'd0, 8'd0, 8'd0, 8'd0};
        w_req  = 4'b0010;
        tick();
        w_req  = 4'b0000;
        n_cmp++;
        if (r_gnt !== 4'b0010 || r_cnt !== 8'd0 || r_wrap !== 1'b0 || r_busy !== 1'b1) begin
            n_err++;
            $display("FAIL step0: gnt=%b cnt=%0d wrap=%b busy=%b, want 0010/0/0/1", r_gnt, r_cnt, r_wrap, r_busy);
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        w_step = {8'd0, 8'd2, 8'd5, 8'd0};
        w_req  = 4'b0010;
        tick();
        w_req  = 4'b0000;
        n_cmp++;
        if (r_gnt !== 4'b0010 || r_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL rstmid_setup: gnt=%b cnt=%0d, want gnt=0010 cnt=5", r_gnt, r_cnt);
        end
        #2;
        w_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (r_gnt !== 4'b0000 || r_cnt !== 8'd0 || r_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: gnt=%b cnt=%0d busy=%b, want all 0", r_gnt, r_cnt, r_busy);
        end
        w_rst_n = 1'b1;
        w_req   = 4'b0110;
        tick();
        w_req   = 4'b0000;
        n_cmp++;
        if (r_gnt !== 4'b0010 || r_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL rstmid_first: gnt=%b cnt=%0d, want gnt=0010 cnt=5", r_gnt, r_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_wrap();
        test_hold();
        test_clr();
        test_step0();
        test_reset_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
